alu_uop_issue: RTL

- EX-stage producer for the ALU operand/micro-opcode interface.
- Accepts decoded RV32I fields from ID over a valid/ready handshake and translates opcode/funct3/funct7[5] into the 4-bit ALU micro-opcode.
- Selects the A/B operands and presents them, registered, to the ALU through a 2-entry skid buffer.
- Sustains one op per cycle under backpressure and supports pipeline flush.

---
 rtl/core101_alu_pkg.sv | 52 +++++
 rtl/alu_uop_decode.sv | 51 +++++
 rtl/alu_uop_issue.sv | 113 +++++++++++
 3 files changed

// File: rtl/core101_alu_pkg.sv
// rtl/core101_alu_pkg.sv - shared ALU micro-opcode, RV32I opcode and entry definitions
// Contents: uop code localparams, OP/OP_IMM/LUI/AUIPC opcodes, ALU entry
// struct and width, and the funct3 -> uop mapping shared by OP and OP-IMM.
package core101_alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] UOP_ADD     = 4'b0000;
  localparam logic [3:0] UOP_SUB     = 4'b0001;
  localparam logic [3:0] UOP_OR      = 4'b0010;
  localparam logic [3:0] UOP_AND     = 4'b0011;
  localparam logic [3:0] UOP_XOR     = 4'b0100;
  localparam logic [3:0] UOP_BUF_RS1 = 4'b1000;
  localparam logic [3:0] UOP_BUF_RS2 = 4'b1001;
  localparam logic [3:0] UOP_SLT     = 4'b1010;
  localparam logic [3:0] UOP_SLTU    = 4'b1011;
  localparam logic [3:0] UOP_SRA     = 4'b1101;
  localparam logic [3:0] UOP_SRL     = 4'b1110;
  localparam logic [3:0] UOP_SLL     = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic            illegal;
    logic [3:0]      uop;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } alu_entry_t;

  localparam int ALU_ENTRY_W = $bits(alu_entry_t);

  // alt selects SUB at funct3=000 and SRA at funct3=101; ignored elsewhere.
  function automatic logic [3:0] funct3_uop(input logic [2:0] funct3, input logic alt);
    logic [3:0] u;
    case (funct3)
      3'b000:  u = alt ? UOP_SUB : UOP_ADD;
      3'b001:  u = UOP_SLL;
      3'b010:  u = UOP_SLT;
      3'b011:  u = UOP_SLTU;
      3'b100:  u = UOP_XOR;
      3'b101:  u = alt ? UOP_SRA : UOP_SRL;
      3'b110:  u = UOP_OR;
      default: u = UOP_AND;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/alu_uop_decode.sv
// rtl/alu_uop_decode.sv - combinational RV32I field to ALU operand/uop translation
// Ports: opcode/funct3/funct7b5 and rs1/rs2/imm/pc in; a_data/b_data/uop/illegal out.
module alu_uop_decode
  import core101_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] a_data,
  output logic [DATA_WIDTH-1:0] b_data,
  output logic [3:0]            uop,
  output logic                  illegal
);

  always_comb begin
    a_data  = '0;
    b_data  = '0;
    uop     = UOP_ADD;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        a_data = rs1_data;
        b_data = rs2_data;
        uop    = funct3_uop(funct3, funct7b5);
      end
      OPC_OP_IMM: begin
        a_data  = rs1_data;
        b_data  = imm;
        // There is no SUBI: funct7b5 only matters for the shift-right pair.
        uop     = funct3_uop(funct3, funct7b5 & (funct3 != 3'b000));
        illegal = (funct3 == 3'b001) & funct7b5;
      end
      OPC_LUI: begin
        b_data = imm;
        uop    = UOP_BUF_RS2;
      end
      OPC_AUIPC: begin
        a_data = pc;
        b_data = imm;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_uop_issue.sv
// rtl/alu_uop_issue.sv - EX-stage ALU operand/uop issue with 2-entry skid buffer
// Ports: clk_in, rst_n_in (sync active-low), flush_in; ID side in_valid_in/in_ready_out
// with opcode/funct3/funct7b5/rs1/rs2/imm/pc; ALU side out_valid_out/out_ready_in with
// a_data_out/b_data_out/uop_out/illegal_out.
// Macro ALU_UOP_ISSUE_PERF_EN adds issue_count_out and stall_count_out.
module alu_uop_issue
  import core101_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  flush_in,
  input  logic                  in_valid_in,
  output logic                  in_ready_out,
  input  logic [6:0]            opcode_in,
  input  logic [2:0]            funct3_in,
  input  logic                  funct7b5_in,
  input  logic [DATA_WIDTH-1:0] rs1_data_in,
  input  logic [DATA_WIDTH-1:0] rs2_data_in,
  input  logic [DATA_WIDTH-1:0] imm_in,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic                  out_valid_out,
  input  logic                  out_ready_in,
  output logic [DATA_WIDTH-1:0] a_data_out,
  output logic [DATA_WIDTH-1:0] b_data_out,
  output logic [3:0]            uop_out,
  output logic                  illegal_out
`ifdef ALU_UOP_ISSUE_PERF_EN
  ,
  output logic [31:0]           issue_count_out,
  output logic [31:0]           stall_count_out
`endif
);

  typedef struct packed {
    logic                  valid;
    logic                  illegal;
    logic [3:0]            uop;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } entry_t;

  entry_t                m_q, s_q, dec_e;
  logic [DATA_WIDTH-1:0] dec_a, dec_b;
  logic [3:0]            dec_uop;
  logic                  dec_illegal;
  logic                  accept, consume;

  alu_uop_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .opcode   (opcode_in),
    .funct3   (funct3_in),
    .funct7b5 (funct7b5_in),
    .rs1_data (rs1_data_in),
    .rs2_data (rs2_data_in),
    .imm      (imm_in),
    .pc       (pc_in),
    .a_data   (dec_a),
    .b_data   (dec_b),
    .uop      (dec_uop),
    .illegal  (dec_illegal)
  );

  assign dec_e = '{valid: 1'b1, illegal: dec_illegal, uop: dec_uop, a: dec_a, b: dec_b};

  // Ready depends only on S, so it is a pure register output.
  assign in_ready_out = ~s_q.valid;
  assign accept       = in_valid_in & in_ready_out;
  assign consume      = m_q.valid & out_ready_in;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      m_q <= '0;
      s_q <= '0;
    end else if (flush_in) begin
      m_q.valid <= 1'b0;
      s_q.valid <= 1'b0;
    end else if (consume || !m_q.valid) begin
      // S is older than any new input, so it always refills M first.
      // While S is valid in_ready_out is low, so no input can be lost here.
      if (s_q.valid) begin
        m_q       <= s_q;
        s_q.valid <= 1'b0;
      end else if (accept) begin
        m_q <= dec_e;
      end else begin
        m_q.valid <= 1'b0;
      end
    end else if (accept) begin
      s_q <= dec_e;
    end
  end

  assign out_valid_out = m_q.valid;
  assign a_data_out    = m_q.a;
  assign b_data_out    = m_q.b;
  assign uop_out       = m_q.uop;
  assign illegal_out   = m_q.illegal;

`ifdef ALU_UOP_ISSUE_PERF_EN
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      issue_count_out <= '0;
      stall_count_out <= '0;
    end else begin
      // A flush overrides the consume, so that edge is not an issue.
      if (consume && !flush_in) issue_count_out <= issue_count_out + 32'd1;
      if (m_q.valid && !out_ready_in) stall_count_out <= stall_count_out + 32'd1;
    end
  end
`endif

endmodule
